// File: rtl/pa_noc.sv
// Shared NoC definitions for the APB-over-mesh network interfaces.
//   - Packet field offsets/widths and total packet width
//   - APB address bit positions carrying the destination coordinates
//   - NI requester state enum
//   - Packed packet struct with pack/unpack helpers
package pa_noc;

  localparam int unsigned COORD_W          = 2;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned APB_PACKET_WIDTH = 76;

  localparam int unsigned DST_COL_LSB = 0;
  localparam int unsigned DST_ROW_LSB = 2;
  localparam int unsigned SRC_COL_LSB = 4;
  localparam int unsigned SRC_ROW_LSB = 6;
  localparam int unsigned VALID_BIT   = 8;
  localparam int unsigned IS_RSP_BIT  = 9;
  localparam int unsigned WRITE_BIT   = 10;
  localparam int unsigned SLVERR_BIT  = 11;
  localparam int unsigned ADDR_LSB    = 12;
  localparam int unsigned DATA_LSB    = 44;

  // Destination coordinates live in the top address bits.
  localparam int unsigned PADDR_ROW_MSB = 31;
  localparam int unsigned PADDR_COL_MSB = 29;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitRsp,
    StComplete
  } ni_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic               slverr;
    logic               write;
    logic               is_response;
    logic               valid;
    logic [COORD_W-1:0] src_row;
    logic [COORD_W-1:0] src_col;
    logic [COORD_W-1:0] dst_row;
    logic [COORD_W-1:0] dst_col;
  } apb_packet_t;

  function automatic logic [APB_PACKET_WIDTH-1:0] pack_packet(input apb_packet_t p);
    logic [APB_PACKET_WIDTH-1:0] v;
    v = '0;
    v[DST_COL_LSB +: COORD_W] = p.dst_col;
    v[DST_ROW_LSB +: COORD_W] = p.dst_row;
    v[SRC_COL_LSB +: COORD_W] = p.src_col;
    v[SRC_ROW_LSB +: COORD_W] = p.src_row;
    v[VALID_BIT]              = p.valid;
    v[IS_RSP_BIT]             = p.is_response;
    v[WRITE_BIT]              = p.write;
    v[SLVERR_BIT]             = p.slverr;
    v[ADDR_LSB +: ADDR_W]     = p.addr;
    v[DATA_LSB +: DATA_W]     = p.data;
    return v;
  endfunction

  function automatic apb_packet_t unpack_packet(input logic [APB_PACKET_WIDTH-1:0] v);
    apb_packet_t p;
    p.dst_col     = v[DST_COL_LSB +: COORD_W];
    p.dst_row     = v[DST_ROW_LSB +: COORD_W];
    p.src_col     = v[SRC_COL_LSB +: COORD_W];
    p.src_row     = v[SRC_ROW_LSB +: COORD_W];
    p.valid       = v[VALID_BIT];
    p.is_response = v[IS_RSP_BIT];
    p.write       = v[WRITE_BIT];
    p.slverr      = v[SLVERR_BIT];
    p.addr        = v[ADDR_LSB +: ADDR_W];
    p.data        = v[DATA_LSB +: DATA_W];
    return p;
  endfunction

endpackage

// File: rtl/apb_requester_ni.sv
// Requester-side network interface. APB completer toward a local master; each
// transfer becomes one request packet to the attached router, then the NI waits
// for the matching response (or a timeout) and completes the APB transfer.
// One outstanding transaction.
// Ports:
//   i_clk, i_srst                 clock, synchronous active-high reset
//   i_psel/i_penable/i_pwrite     APB control from the local master
//   i_paddr, i_pwdata             APB address (dst coords in [31:28]) and write data
//   o_prdata/o_pready/o_pslverr   APB completion, only during the handshake cycle
//   o_apbPacket                   request packet to router, one cycle, else zero
//   i_apbPacket                   packet from router, zero when idle
module apb_requester_ni
  import pa_noc::*;
#(
  parameter int unsigned GRID_WIDTH     = 4,
  parameter int unsigned NI_ROW         = 0,
  parameter int unsigned NI_COL         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        i_clk,
  input  logic                        i_srst,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [31:0]                 i_paddr,
  input  logic [31:0]                 i_pwdata,
  output logic [31:0]                 o_prdata,
  output logic                        o_pready,
  output logic                        o_pslverr,
  output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
  input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket
);

  localparam int unsigned COORD_WIDTH = $clog2(GRID_WIDTH);
  localparam int unsigned CntW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [COORD_W-1:0] OwnRow     = COORD_W'(NI_ROW);
  localparam logic [COORD_W-1:0] OwnCol     = COORD_W'(NI_COL);
  localparam logic [CntW-1:0]    CntMax     = '1;
  localparam logic [CntW-1:0]    TimeoutVal = CntW'(TIMEOUT_CYCLES);

  ni_state_e          state_q, state_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [COORD_W-1:0] dst_row_q, dst_row_d;
  logic [COORD_W-1:0] dst_col_q, dst_col_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  apb_packet_t        rx;
  apb_packet_t        tx;
  logic [COORD_W-1:0] req_row, req_col;
  logic               rsp_match;
  logic [CntW-1:0]    cnt_inc;
  logic               unused_rx;

  assign rx        = unpack_packet(i_apbPacket);
  assign unused_rx = ^{rx.addr, rx.write};

  assign req_row = COORD_W'(i_paddr[PADDR_ROW_MSB -: COORD_WIDTH]);
  assign req_col = COORD_W'(i_paddr[PADDR_COL_MSB -: COORD_WIDTH]);

  // Only a response from the node we addressed, sent to us, completes the transfer.
  assign rsp_match = rx.valid && rx.is_response &&
                     (rx.dst_row == OwnRow) && (rx.dst_col == OwnCol) &&
                     (rx.src_row == dst_row_q) && (rx.src_col == dst_col_q);

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dst_row_d   = dst_row_q;
    dst_col_d   = dst_col_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    tx          = '0;
    o_apbPacket = '0;
    o_pready    = 1'b0;
    o_pslverr   = 1'b0;
    o_prdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (i_psel && !i_penable) begin
          write_d   = i_pwrite;
          addr_d    = i_paddr;
          wdata_d   = i_pwdata;
          dst_row_d = req_row;
          dst_col_d = req_col;
          rdata_d   = '0;
          if ((req_row == OwnRow) && (req_col == OwnCol)) begin
            // Self-addressed: nothing on the mesh can answer, fail locally.
            err_d   = 1'b1;
            state_d = StComplete;
          end else begin
            err_d   = 1'b0;
            state_d = StSend;
          end
        end
      end
      StSend: begin
        tx.data        = write_q ? wdata_q : '0;
        tx.addr        = addr_q;
        tx.write       = write_q;
        tx.valid       = 1'b1;
        tx.src_row     = OwnRow;
        tx.src_col     = OwnCol;
        tx.dst_row     = dst_row_q;
        tx.dst_col     = dst_col_q;
        o_apbPacket    = pack_packet(tx);
        cnt_d          = '0;
        state_d        = StWaitRsp;
      end
      StWaitRsp: begin
        cnt_d = cnt_inc;
        // Acceptance is checked first so it wins over a coincident timeout.
        if (rsp_match) begin
          rdata_d = rx.data;
          err_d   = rx.slverr;
          state_d = StComplete;
        end else if (cnt_inc >= TimeoutVal) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StComplete;
        end
      end
      StComplete: begin
        if (i_psel && i_penable) begin
          o_pready  = 1'b1;
          o_pslverr = err_q;
          o_prdata  = write_q ? '0 : rdata_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dst_row_q <= '0;
      dst_col_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dst_row_q <= dst_row_d;
      dst_col_q <= dst_col_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_requester_ni.sv
// Self-checking bench for apb_requester_ni at NI(0,0), TIMEOUT_CYCLES=8.
// Expected packets and APB completions are queued when stimulus is driven and
// compared when the DUT emits a packet or completes the transfer.
module tb_apb_requester_ni;

  localparam int unsigned PW = 76;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } rsp_t;

  logic          i_clk;
  logic          i_srst;
  logic          i_psel;
  logic          i_penable;
  logic          i_pwrite;
  logic [31:0]   i_paddr;
  logic [31:0]   i_pwdata;
  logic [31:0]   o_prdata;
  logic          o_pready;
  logic          o_pslverr;
  logic [PW-1:0] o_apbPacket;
  logic [PW-1:0] i_apbPacket;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [PW-1:0] exp_pkt_q[$];
  rsp_t          exp_rsp_q[$];
  logic [PW-1:0] seen_pkt_q[$];
  int            seen_cyc_q[$];

  apb_requester_ni #(
    .GRID_WIDTH    (4),
    .NI_ROW        (0),
    .NI_COL        (0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk      (i_clk),
    .i_srst     (i_srst),
    .i_psel     (i_psel),
    .i_penable  (i_penable),
    .i_pwrite   (i_pwrite),
    .i_paddr    (i_paddr),
    .i_pwdata   (i_pwdata),
    .o_prdata   (o_prdata),
    .o_pready   (o_pready),
    .o_pslverr  (o_pslverr),
    .o_apbPacket(o_apbPacket),
    .i_apbPacket(i_apbPacket)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Record every non-idle request packet with the cycle it appeared in.
  always @(negedge i_clk) begin
    if (o_apbPacket !== '0) begin
      seen_pkt_q.push_back(o_apbPacket);
      seen_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Layout: {data, addr, slverr, write, isResponse, valid, srcRow, srcCol, dstRow, dstCol}
  function automatic logic [PW-1:0] mk_pkt(input logic [1:0] dr, input logic [1:0] dc,
                                           input logic [1:0] sr, input logic [1:0] sc,
                                           input logic rsp, input logic wr, input logic err,
                                           input logic [31:0] addr, input logic [31:0] data);
    return {data, addr, err, wr, rsp, 1'b1, sr, sc, dr, dc};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Setup phase in the current cycle; returns one cycle later in access phase.
  task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    i_psel    = 1'b1;
    i_penable = 1'b0;
    i_pwrite  = wr;
    i_paddr   = addr;
    i_pwdata  = wdata;
    tick();
    i_penable = 1'b1;
  endtask

  task automatic send_pkt(input logic [PW-1:0] p);
    i_apbPacket = p;
    tick();
    i_apbPacket = '0;
  endtask

  task automatic wait_ready(input int max_cyc, output bit got, output logic [31:0] rd,
                            output logic err, output int n);
    got = 1'b0;
    rd  = '0;
    err = 1'b0;
    n   = 0;
    while (!got && n < max_cyc) begin
      @(negedge i_clk);
      if (o_pready === 1'b1) begin
        got = 1'b1;
        rd  = o_prdata;
        err = o_pslverr;
      end
      tick();
      n++;
    end
    i_psel    = 1'b0;
    i_penable = 1'b0;
  endtask

  task automatic test_reset();
    i_srst = 1'b1;
    repeat (3) tick();
    @(negedge i_clk);
    checks++;
    if (o_pready !== 1'b0) begin
      failures++;
      $display("FAIL reset_pready: got=%b exp=0", o_pready);
    end
    checks++;
    if (o_pslverr !== 1'b0) begin
      failures++;
      $display("FAIL reset_pslverr: got=%b exp=0", o_pslverr);
    end
    checks++;
    if (o_prdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_prdata: got=%h exp=0", o_prdata);
    end
    checks++;
    if (o_apbPacket !== '0) begin
      failures++;
      $display("FAIL reset_packet: got=%h exp=0", o_apbPacket);
    end
    tick();
    i_srst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int t, n;
    bit got;
    logic [31:0] rd;
    logic err;
    rsp_t e;
    logic [PW-1:0] ep;
    exp_pkt_q.push_back(mk_pkt(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0,
                               32'h6000_0010, 32'hDEAD_BEEF));
    exp_rsp_q.push_back('{err: 1'b0, rd: 32'h0});
    t = cyc;
    apb_setup(1'b1, 32'h6000_0010, 32'hDEAD_BEEF);
    repeat (5) tick();
    send_pkt(mk_pkt(2'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 32'h6000_0010, 32'h5555_AAAA));
    wait_ready(30, got, rd, err, n);
    e = exp_rsp_q.pop_front();
    checks++;
    if (!got || n != 1) begin
      failures++;
      $display("FAIL write_ready_latency: got=%0b cycles=%0d exp got=1 cycles=1", got, n);
    end
    checks++;
    if (err !== e.err || rd !== e.rd) begin
      failures++;
      $display("FAIL write_completion: err=%b rd=%h exp err=%b rd=%h", err, rd, e.err, e.rd);
    end
    ep = exp_pkt_q.pop_front();
    checks++;
    if (seen_pkt_q.size() != 1) begin
      failures++;
      $display("FAIL write_pkt_count: got=%0d exp=1", seen_pkt_q.size());
    end else begin
      checks++;
      if (seen_pkt_q[0] !== ep || seen_cyc_q[0] != t + 1) begin
        failures++;
        $display("FAIL write_pkt: got=%h@%0d exp=%h@%0d", seen_pkt_q[0], seen_cyc_q[0], ep, t + 1);
      end
    end
    seen_pkt_q.delete();
    seen_cyc_q.delete();
  endtask

  task automatic test_read();
    logic [31:0] rdat[2];
    logic        rerr[2];
    rdat[0] = 32'h1234_5678;
    rerr[0] = 1'b0;
    rdat[1] = 32'h0000_BEEF;
    rerr[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int n;
      bit got;
      logic [31:0] rd;
      logic err;
      rsp_t e;
      logic [PW-1:0] ep;
      exp_pkt_q.push_back(mk_pkt(2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0,
                                 32'h4000_0000, 32'h0));
      exp_rsp_q.push_back('{err: rerr[i], rd: rdat[i]});
      apb_setup(1'b0, 32'h4000_0000, 32'hFFFF_FFFF);
      tick();
      send_pkt(mk_pkt(2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, rerr[i], 32'h4000_0000, rdat[i]));
      wait_ready(30, got, rd, err, n);
      e = exp_rsp_q.pop_front();
      checks++;
      if (!got || n != 1) begin
        failures++;
        $display("FAIL read%0d_ready_latency: got=%0b cycles=%0d exp got=1 cycles=1", i, got, n);
      end
      checks++;
      if (err !== e.err || rd !== e.rd) begin
        failures++;
        $display("FAIL read%0d_completion: err=%b rd=%h exp err=%b rd=%h",
                 i, err, rd, e.err, e.rd);
      end
      ep = exp_pkt_q.pop_front();
      checks++;
      if (seen_pkt_q.size() != 1 || seen_pkt_q[0] !== ep) begin
        failures++;
        $display("FAIL read%0d_pkt: count=%0d exp count=1 pkt=%h", i, seen_pkt_q.size(), ep);
      end
      seen_pkt_q.delete();
      seen_cyc_q.delete();
    end
  endtask

  task automatic test_timeout();
    int n;
    bit got, bad;
    logic [31:0] rd;
    logic err;
    rsp_t e;
    logic [PW-1:0] ep;
    exp_pkt_q.push_back(mk_pkt(2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'h0));
    exp_rsp_q.push_back('{err: 1'b1, rd: 32'h0});
    apb_setup(1'b0, 32'h4000_0000, 32'h0);
    wait_ready(30, got, rd, err, n);
    e = exp_rsp_q.pop_front();
    // SEND cycle plus TO wait cycles, completion in the next one.
    checks++;
    if (!got || n != TO + 2) begin
      failures++;
      $display("FAIL timeout_latency: got=%0b cycles=%0d exp got=1 cycles=%0d", got, n, TO + 2);
    end
    checks++;
    if (err !== e.err || rd !== e.rd) begin
      failures++;
      $display("FAIL timeout_completion: err=%b rd=%h exp err=%b rd=%h", err, rd, e.err, e.rd);
    end
    ep = exp_pkt_q.pop_front();
    checks++;
    if (seen_pkt_q.size() != 1 || seen_pkt_q[0] !== ep) begin
      failures++;
      $display("FAIL timeout_pkt: count=%0d exp count=1 pkt=%h", seen_pkt_q.size(), ep);
    end
    seen_pkt_q.delete();
    seen_cyc_q.delete();
    tick();
    tick();
    send_pkt(mk_pkt(2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h7777_7777));
    bad = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_pready !== 1'b0 || o_pslverr !== 1'b0 || o_prdata !== 32'h0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad || seen_pkt_q.size() != 0) begin
      failures++;
      $display("FAIL late_rsp_ignored: outputs_active=%0b pkts=%0d exp 0 and 0",
               bad, seen_pkt_q.size());
    end
    seen_pkt_q.delete();
    seen_cyc_q.delete();
  endtask

  task automatic test_self_addr();
    int n;
    bit got;
    logic [31:0] rd;
    logic err;
    rsp_t e;
    exp_rsp_q.push_back('{err: 1'b1, rd: 32'h0});
    apb_setup(1'b0, 32'h0000_0004, 32'h0);
    wait_ready(30, got, rd, err, n);
    repeat (3) tick();
    e = exp_rsp_q.pop_front();
    checks++;
    if (!got || n != 1) begin
      failures++;
      $display("FAIL self_ready: got=%0b cycles=%0d exp got=1 cycles=1", got, n);
    end
    checks++;
    if (err !== e.err || rd !== e.rd) begin
      failures++;
      $display("FAIL self_completion: err=%b rd=%h exp err=%b rd=%h", err, rd, e.err, e.rd);
    end
    checks++;
    if (seen_pkt_q.size() != 0) begin
      failures++;
      $display("FAIL self_no_pkt: count=%0d exp=0", seen_pkt_q.size());
    end
    seen_pkt_q.delete();
    seen_cyc_q.delete();
  endtask

  task automatic test_filter();
    logic [PW-1:0] bad_pkt[3];
    int n;
    bit got;
    logic [31:0] rd;
    logic err;
    rsp_t e;
    // Destination (2,0): wrong src, request type, addressed elsewhere.
    bad_pkt[0] = mk_pkt(2'd0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h1111_1111);
    bad_pkt[1] = mk_pkt(2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h2222_2222);
    bad_pkt[2] = mk_pkt(2'd0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h3333_3333);
    exp_rsp_q.push_back('{err: 1'b0, rd: 32'h0BAD_F00D});
    apb_setup(1'b0, 32'h8000_0000, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      send_pkt(bad_pkt[i]);
      @(negedge i_clk);
      checks++;
      if (o_pready !== 1'b0) begin
        failures++;
        $display("FAIL filter_ignore%0d: pready=%b exp=0", i, o_pready);
      end
      tick();
    end
    send_pkt(mk_pkt(2'd0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0BAD_F00D));
    wait_ready(30, got, rd, err, n);
    e = exp_rsp_q.pop_front();
    checks++;
    if (!got || n != 1 || err !== e.err || rd !== e.rd) begin
      failures++;
      $display("FAIL filter_accept: got=%0b cycles=%0d err=%b rd=%h exp 1 1 %b %h",
               got, n, err, rd, e.err, e.rd);
    end
    // Response lands in the final wait cycle, same cycle as the timeout.
    exp_rsp_q.push_back('{err: 1'b0, rd: 32'hC0DE_0042});
    apb_setup(1'b0, 32'h8000_0000, 32'h0);
    repeat (TO) tick();
    send_pkt(mk_pkt(2'd0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hC0DE_0042));
    wait_ready(30, got, rd, err, n);
    e = exp_rsp_q.pop_front();
    checks++;
    if (!got || n != 1 || err !== e.err || rd !== e.rd) begin
      failures++;
      $display("FAIL rsp_vs_timeout: got=%0b cycles=%0d err=%b rd=%h exp 1 1 %b %h",
               got, n, err, rd, e.err, e.rd);
    end
    checks++;
    if (seen_pkt_q.size() != 2) begin
      failures++;
      $display("FAIL filter_pkt_count: got=%0d exp=2", seen_pkt_q.size());
    end
    seen_pkt_q.delete();
    seen_cyc_q.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    bit got;
    logic [31:0] rd;
    logic err;
    rsp_t e;
    apb_setup(1'b0, 32'h4000_0000, 32'h0);
    tick();
    tick();
    i_srst = 1'b1;
    tick();
    i_srst    = 1'b0;
    i_psel    = 1'b0;
    i_penable = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_pready !== 1'b0 || o_pslverr !== 1'b0 || o_prdata !== 32'h0 || o_apbPacket !== '0)
    begin
      failures++;
      $display("FAIL midreset_outputs: pready=%b pslverr=%b prdata=%h pkt=%h exp all 0",
               o_pready, o_pslverr, o_prdata, o_apbPacket);
    end
    tick();
    send_pkt(mk_pkt(2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'hBAD0_0000));
    tick();
    seen_pkt_q.delete();
    seen_cyc_q.delete();
    exp_pkt_q.push_back(mk_pkt(2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'h0));
    exp_rsp_q.push_back('{err: 1'b0, rd: 32'h600D_600D});
    apb_setup(1'b0, 32'h4000_0000, 32'h0);
    tick();
    tick();
    send_pkt(mk_pkt(2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h600D_600D));
    wait_ready(30, got, rd, err, n);
    e = exp_rsp_q.pop_front();
    checks++;
    if (!got || n != 1 || err !== e.err || rd !== e.rd) begin
      failures++;
      $display("FAIL after_reset_xfer: got=%0b cycles=%0d err=%b rd=%h exp 1 1 %b %h",
               got, n, err, rd, e.err, e.rd);
    end
    checks++;
    if (seen_pkt_q.size() != 1 || seen_pkt_q[0] !== exp_pkt_q[0]) begin
      failures++;
      $display("FAIL after_reset_pkt: count=%0d exp count=1 pkt=%h",
               seen_pkt_q.size(), exp_pkt_q[0]);
    end
    void'(exp_pkt_q.pop_front());
    seen_pkt_q.delete();
    seen_cyc_q.delete();
  endtask

  initial begin
    i_srst      = 1'b1;
    i_psel      = 1'b0;
    i_penable   = 1'b0;
    i_pwrite    = 1'b0;
    i_paddr     = '0;
    i_pwdata    = '0;
    i_apbPacket = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_self_addr();
    test_filter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
